// File: rtl/pagerank_mem_arbiter_if.sv
// Requester-side and memory-side handshake bundle for pagerank_mem_arbiter.
// slave = the arbiter's view, master = the surrounding system's view.
interface pagerank_mem_arbiter_if #(
  parameter int NPORTS     = 4,
  parameter int REQ_NBITS  = 77,
  parameter int RESP_NBITS = 47,
  parameter int MAX_OUTST  = 4
);
  localparam int CNT_W = $clog2(MAX_OUTST) + 1;

  logic [NPORTS*REQ_NBITS-1:0] req_msg;
  logic [NPORTS-1:0]           req_val;
  logic [NPORTS-1:0]           req_rdy;
  logic [RESP_NBITS-1:0]       resp_msg;
  logic [NPORTS-1:0]           resp_val;
  logic [NPORTS-1:0]           resp_rdy;
  logic [REQ_NBITS-1:0]        mem_req_msg;
  logic                        mem_req_val;
  logic                        mem_req_rdy;
  logic [RESP_NBITS-1:0]       mem_resp_msg;
  logic                        mem_resp_val;
  logic                        mem_resp_rdy;
  logic [CNT_W-1:0]            outst_cnt;
  logic                        err_stray;

  modport slave (
    input  req_msg, req_val, resp_rdy, mem_req_rdy, mem_resp_msg, mem_resp_val,
    output req_rdy, resp_msg, resp_val, mem_req_msg, mem_req_val, mem_resp_rdy,
    output outst_cnt, err_stray
  );

  modport master (
    output req_msg, req_val, resp_rdy, mem_req_rdy, mem_resp_msg, mem_resp_val,
    input  req_rdy, resp_msg, resp_val, mem_req_msg, mem_req_val, mem_resp_rdy,
    input  outst_cnt, err_stray
  );
endinterface

// File: rtl/pagerank_mem_arbiter.sv
// Round-robin arbiter sharing one in-order memory port; a tag FIFO steers responses back.
// Optional feature macro: PAGERANK_ARB_STRAY_DROP_EN (drop responses that arrive with an empty FIFO).
module pagerank_mem_arbiter #(
  parameter int NPORTS     = 4,
  parameter int REQ_NBITS  = 77,
  parameter int RESP_NBITS = 47,
  parameter int MAX_OUTST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  pagerank_mem_arbiter_if.slave bus
);
  localparam int PTR_W  = $clog2(NPORTS);
  localparam int ADDR_W = $clog2(MAX_OUTST);
  localparam int CNT_W  = ADDR_W + 1;

  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  r_tag [MAX_OUTST];
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err_stray;

  logic [PTR_W-1:0]  w_gnt;
  logic [PTR_W-1:0]  w_gnt_next;
  logic [PTR_W-1:0]  w_head;
  logic [PTR_W:0]    w_sum;
  logic              w_found;
  logic              w_any;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_stray;

  assign w_any      = |bus.req_val;
  assign w_full     = (r_cnt == CNT_W'(MAX_OUTST));
  assign w_empty    = (r_cnt == {CNT_W{1'b0}});
  assign w_push     = w_any && !w_full && bus.mem_req_rdy;
  assign w_pop      = bus.mem_resp_val && bus.mem_resp_rdy && !w_empty;
  assign w_head     = r_tag[r_rd_addr];
  assign w_gnt_next = (w_gnt == PTR_W'(NPORTS - 1)) ? {PTR_W{1'b0}} : w_gnt + PTR_W'(1);

  // Rotating-priority scan: first valid requester at or after r_ptr, modulo NPORTS
  always_comb begin
    w_gnt   = {PTR_W{1'b0}};
    w_found = 1'b0;
    w_sum   = {(PTR_W+1){1'b0}};
    for (int k = 0; k < NPORTS; k++) begin
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NPORTS)) begin
        w_sum = w_sum - (PTR_W+1)'(NPORTS);
      end else begin
        w_sum = w_sum;
      end
      if (!w_found && bus.req_val[w_sum[PTR_W-1:0]]) begin
        w_gnt   = w_sum[PTR_W-1:0];
        w_found = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Request path is purely combinational so a grant reaches memory in the same cycle
  always_comb begin
    bus.req_rdy     = {NPORTS{1'b0}};
    bus.mem_req_val = w_any && !w_full;
    if (w_any) begin
      bus.mem_req_msg = bus.req_msg[w_gnt*REQ_NBITS +: REQ_NBITS];
    end else begin
      bus.mem_req_msg = {REQ_NBITS{1'b0}};
    end
    for (int i = 0; i < NPORTS; i++) begin
      bus.req_rdy[i] = (w_gnt == PTR_W'(i)) && w_push;
    end
  end

  // Response steering: only the requester recorded at the FIFO head sees the response
  always_comb begin
    bus.resp_msg = bus.mem_resp_msg;
    bus.resp_val = {NPORTS{1'b0}};
    for (int i = 0; i < NPORTS; i++) begin
      bus.resp_val[i] = bus.mem_resp_val && !w_empty && (w_head == PTR_W'(i));
    end
    if (w_empty) begin
`ifdef PAGERANK_ARB_STRAY_DROP_EN
      bus.mem_resp_rdy = bus.mem_resp_val;
`else
      bus.mem_resp_rdy = 1'b0;
`endif
    end else begin
      bus.mem_resp_rdy = bus.resp_rdy[w_head];
    end
  end

`ifdef PAGERANK_ARB_STRAY_DROP_EN
  assign w_stray = bus.mem_resp_val && w_empty;
`else
  assign w_stray = 1'b0;
`endif

  // Tag FIFO, occupancy counter, priority pointer and sticky stray flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr       <= {PTR_W{1'b0}};
      r_wr_addr   <= {ADDR_W{1'b0}};
      r_rd_addr   <= {ADDR_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_err_stray <= 1'b0;
      for (int i = 0; i < MAX_OUTST; i++) begin
        r_tag[i] <= {PTR_W{1'b0}};
      end
    end else begin
      if (w_push) begin
        r_tag[r_wr_addr] <= w_gnt;
        r_wr_addr        <= r_wr_addr + ADDR_W'(1);
        r_ptr            <= w_gnt_next;
      end else begin
        r_ptr <= r_ptr;
      end
      if (w_pop) begin
        r_rd_addr <= r_rd_addr + ADDR_W'(1);
      end else begin
        r_rd_addr <= r_rd_addr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
      r_err_stray <= r_err_stray | w_stray;
    end
  end

  assign bus.outst_cnt = r_cnt;
  assign bus.err_stray = r_err_stray;
endmodule

// File: tb/tb_pagerank_mem_arbiter.sv
// Directed bench for pagerank_mem_arbiter: requester and memory models plus a response scoreboard.
module tb_pagerank_mem_arbiter;
  localparam int NP = 4;
  localparam int RQ = 77;
  localparam int RS = 47;
  localparam int MO = 4;
`ifdef PAGERANK_ARB_STRAY_DROP_EN
  localparam logic DROP = 1'b1;
`else
  localparam logic DROP = 1'b0;
`endif
  localparam logic [RS-1:0] STRAY_MSG = 47'h0000_0000_5A5A;

  typedef struct { int rdy_cyc; logic [RS-1:0] msg; } mem_ent_t;
  typedef struct { int port; logic [RS-1:0] msg; } exp_ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pagerank_mem_arbiter_if #(.NPORTS(NP), .REQ_NBITS(RQ), .RESP_NBITS(RS), .MAX_OUTST(MO)) bus();
  pagerank_mem_arbiter #(.NPORTS(NP), .REQ_NBITS(RQ), .RESP_NBITS(RS), .MAX_OUTST(MO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  mem_ent_t    mem_q[$];
  exp_ent_t    exp_q[$];
  int          gnt_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc_n = 0;
  int          lat = 1;
  int          rem [NP];
  logic [31:0] addr_d [NP];
  logic [NP-1:0] rrdy_d;
  bit          mem_en;
  bit          stray_inj;
  int          cnt_seq [4] = '{1, 2, 1, 0};

  function automatic logic [RQ-1:0] mk_req(input int p, input logic [31:0] a);
    return {3'd0, 8'(p), a, 2'd0, 32'd0};
  endfunction

  function automatic logic [RS-1:0] mk_resp(input logic [31:0] a);
    return {3'd0, 8'd0, 4'd0, a ^ 32'hA5A5_0000};
  endfunction

  function automatic logic [NP-1:0] onehot(input int p);
    logic [NP-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive models at the negedge, score handshakes, advance past the posedge
  task automatic tick();
    int g;
    exp_ent_t e;
    for (int p = 0; p < NP; p++) begin
      bus.req_val[p] = (rem[p] > 0);
      bus.req_msg[p*RQ +: RQ] = mk_req(p, addr_d[p]);
    end
    bus.resp_rdy    = rrdy_d;
    bus.mem_req_rdy = 1'b1;
    if (stray_inj) begin
      bus.mem_resp_val = 1'b1;
      bus.mem_resp_msg = STRAY_MSG;
    end else if (mem_en && mem_q.size() > 0 && mem_q[0].rdy_cyc <= cyc_n) begin
      bus.mem_resp_val = 1'b1;
      bus.mem_resp_msg = mem_q[0].msg;
    end else begin
      bus.mem_resp_val = 1'b0;
      bus.mem_resp_msg = '0;
    end
    #1;
    if (bus.mem_req_val && bus.mem_req_rdy) begin
      if (gnt_q.size() == 0) begin
        chk("unexpected_grant", bus.mem_req_val, 1'b0);
      end else begin
        g = gnt_q.pop_front();
        chk("grant_port", bus.req_rdy, onehot(g));
        chk("mem_req_msg", bus.mem_req_msg, mk_req(g, addr_d[g]));
        exp_q.push_back('{port: g, msg: mk_resp(addr_d[g])});
      end
      mem_q.push_back('{rdy_cyc: cyc_n + lat, msg: mk_resp(bus.mem_req_msg[65:34])});
    end
    if (|(bus.resp_val & bus.resp_rdy)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", bus.resp_val & bus.resp_rdy, '0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_port", bus.resp_val, onehot(e.port));
        chk("resp_msg", bus.resp_msg, e.msg);
      end
    end
    if (bus.mem_resp_val && bus.mem_resp_rdy) begin
      if (stray_inj) stray_inj = 1'b0;
      else if (mem_q.size() > 0) void'(mem_q.pop_front());
    end
    for (int p = 0; p < NP; p++) begin
      if (bus.req_val[p] && bus.req_rdy[p]) begin
        rem[p]--;
        addr_d[p] = addr_d[p] + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (gnt_q.size() > 0 || exp_q.size() > 0 || mem_q.size() > 0); i++) begin
      tick();
    end
    chk("drain_grants", gnt_q.size(), 0);
    chk("drain_resps", exp_q.size(), 0);
  endtask

  task automatic clear_state();
    gnt_q.delete();
    exp_q.delete();
    mem_q.delete();
    stray_inj = 1'b0;
    mem_en    = 1'b1;
    lat       = 1;
    rrdy_d    = '1;
    for (int p = 0; p < NP; p++) begin
      rem[p]    = 0;
      addr_d[p] = 32'h100 + 32'(p) * 32'h1000;
    end
    bus.req_val      = '0;
    bus.req_msg      = '0;
    bus.resp_rdy     = '1;
    bus.mem_req_rdy  = 1'b1;
    bus.mem_resp_val = 1'b0;
    bus.mem_resp_msg = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_state();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_state();
    @(negedge clk);
    chk("rst_cnt", bus.outst_cnt, 0);
    chk("rst_err", bus.err_stray, 1'b0);
    chk("rst_req_rdy", bus.req_rdy, '0);
    chk("rst_mem_req_val", bus.mem_req_val, 1'b0);
    chk("rst_mem_req_msg", bus.mem_req_msg, '0);
    chk("rst_resp_val", bus.resp_val, '0);
    chk("rst_mem_resp_rdy", bus.mem_resp_rdy, 1'b0);
    reset = 1'b0;

    // single requester, two back-to-back reads, two-cycle memory turnaround
    lat    = 2;
    rem[0] = 2;
    gnt_q.push_back(0);
    gnt_q.push_back(0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_outst_cnt", bus.outst_cnt, cnt_seq[i]);
    end
    drain(10);

    // four requesters always valid: strict rotation
    do_reset();
    for (int p = 0; p < NP; p++) rem[p] = 2;
    for (int r = 0; r < 2; r++) for (int p = 0; p < NP; p++) gnt_q.push_back(p);
    drain(40);

    // full FIFO blocks requests, including the cycle a pop happens
    do_reset();
    mem_en = 1'b0;
    rem[1] = 5;
    for (int i = 0; i < 5; i++) gnt_q.push_back(1);
    for (int i = 0; i < 4; i++) tick();
    chk("full_cnt", bus.outst_cnt, MO);
    chk("full_req_rdy", bus.req_rdy, '0);
    chk("full_mem_req_val", bus.mem_req_val, 1'b0);
    tick();
    chk("full_hold_cnt", bus.outst_cnt, MO);
    mem_en = 1'b1;
    tick();
    chk("full_no_bypass_cnt", bus.outst_cnt, MO - 1);
    chk("full_no_bypass_grant", gnt_q.size(), 1);
    tick();
    chk("full_regrant_cnt", bus.outst_cnt, MO - 1);
    chk("full_regrant", gnt_q.size(), 0);
    drain(20);

    // head-of-line stall on requester 1 holds requester 2's response
    do_reset();
    rrdy_d = 4'b1101;
    rem[1] = 1;
    rem[2] = 1;
    gnt_q.push_back(1);
    gnt_q.push_back(2);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("hol_mem_resp_rdy", bus.mem_resp_rdy, 1'b0);
      chk("hol_resp_val", bus.resp_val, 4'b0010);
      tick();
    end
    rrdy_d = '1;
    drain(10);

    // stray response with empty FIFO
    do_reset();
    stray_inj = 1'b1;
    tick();
    chk("stray_mem_resp_rdy", bus.mem_resp_rdy, DROP);
    chk("stray_resp_val", bus.resp_val, '0);
    chk("stray_err", bus.err_stray, DROP);
    stray_inj = 1'b0;
    tick();
    tick();
    chk("stray_err_sticky", bus.err_stray, DROP);

    // asynchronous reset with three outstanding, then pointer restarts at 0
    do_reset();
    mem_en = 1'b0;
    rem[2] = 3;
    for (int i = 0; i < 3; i++) gnt_q.push_back(2);
    for (int i = 0; i < 3; i++) tick();
    chk("pre_rst_cnt", bus.outst_cnt, 3);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_cnt", bus.outst_cnt, 0);
    chk("async_rst_err", bus.err_stray, 1'b0);
    clear_state();
    @(negedge clk);
    reset = 1'b0;
    rem[0] = 1;
    rem[3] = 1;
    gnt_q.push_back(0);
    gnt_q.push_back(3);
    drain(10);
    rem[2] = 1;
    gnt_q.push_back(2);
    drain(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
